pooling_ctrl: RTL and testbench

Sequencer for the 2x2/stride-2 pooling stage. It consumes the raster-order pixel stream from the systolic array (sys_out plus in_valid) and drives the pooling stage's control inputs: x-mux select, register-file write enable, write source, write/read addresses and pooling enable. It also flags when the pooling output holds a finished pooled pixel. Frame geometry is fixed by parameters, and each frame is launched by a start pulse.

---
 rtl/pooling_ctrl.sv | 146 ++++++++++++++
 tb/tb_pooling_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pooling_ctrl.sv
// Control sequencer for a 2x2, stride-2 pooling stage fed by a raster-order pixel stream.
// It drives the x-mux, register-file write/read controls and pool enable, and flags each finished pooled pixel.
module pooling_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        x_sel,
  output logic                        pool_en,
  output logic                        rf_wr_en,
  output logic                        rf_wr_sel,
  output logic [ADDR_W-1:0]           rf_wr_addr,
  output logic [ADDR_W-1:0]           rf_rd_addr,
  output logic                        out_valid,
  output logic [ADDR_W-1:0]           out_col,
  output logic [$clog2(IMG_H/2):0]    out_row
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int OR_W = $clog2(IMG_H/2) + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ocol_q, ocol_d;
  logic [OR_W-1:0]   orow_q, orow_d;
  logic [ADDR_W-1:0] slot_s;

  assign slot_s = ADDR_W'(col_q >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
    end
  end

  // Outputs are combinational so they line up with the same-cycle pixel; the address
  // and output-position registers only remember the last values for idle cycles.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    ocol_d     = ocol_q;
    orow_d     = orow_q;
    busy       = 1'b0;
    done       = 1'b0;
    x_sel      = 1'b1;
    pool_en    = 1'b0;
    rf_wr_en   = 1'b0;
    rf_wr_sel  = 1'b0;
    out_valid  = 1'b0;
    rf_wr_addr = addr_q;
    rf_rd_addr = addr_q;
    out_col    = ocol_q;
    out_row    = orow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (in_valid) begin
          addr_d     = slot_s;
          rf_wr_addr = slot_s;
          rf_rd_addr = slot_s;
          case ({row_q[0], col_q[0]})
            2'b00: begin
              rf_wr_en = 1'b1;
            end
            2'b11: begin
              pool_en   = 1'b1;
              out_valid = 1'b1;
              out_col   = slot_s;
              out_row   = OR_W'(row_q >> 1);
              ocol_d    = slot_s;
              orow_d    = OR_W'(row_q >> 1);
            end
            default: begin
              pool_en   = 1'b1;
              rf_wr_en  = 1'b1;
              rf_wr_sel = 1'b1;
            end
          endcase
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pooling_ctrl.sv
// Directed bench for pooling_ctrl: a 4x4 instance and an 8x2 instance share clock and stimulus,
// both consuming 16 pixels per frame.
module tb_pooling_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic in_valid;

  logic       a_busy, a_done, a_x_sel, a_pool_en, a_rf_wr_en, a_rf_wr_sel, a_out_valid;
  logic [1:0] a_rf_wr_addr, a_rf_rd_addr, a_out_col;
  logic [1:0] a_out_row;

  logic       b_busy, b_done, b_x_sel, b_pool_en, b_rf_wr_en, b_rf_wr_sel, b_out_valid;
  logic [1:0] b_rf_wr_addr, b_rf_rd_addr, b_out_col;
  logic [0:0] b_out_row;

  int checks = 0;
  int errors = 0;

  pooling_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .busy(a_busy), .done(a_done), .x_sel(a_x_sel), .pool_en(a_pool_en),
    .rf_wr_en(a_rf_wr_en), .rf_wr_sel(a_rf_wr_sel),
    .rf_wr_addr(a_rf_wr_addr), .rf_rd_addr(a_rf_rd_addr),
    .out_valid(a_out_valid), .out_col(a_out_col), .out_row(a_out_row)
  );

  pooling_ctrl #(.IMG_W(8), .IMG_H(2), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .busy(b_busy), .done(b_done), .x_sel(b_x_sel), .pool_en(b_pool_en),
    .rf_wr_en(b_rf_wr_en), .rf_wr_sel(b_rf_wr_sel),
    .rf_wr_addr(b_rf_wr_addr), .rf_rd_addr(b_rf_rd_addr),
    .out_valid(b_out_valid), .out_col(b_out_col), .out_row(b_out_row)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic s, input logic v);
    @(negedge clk);
    start    = s;
    in_valid = v;
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    #2;
    got = {a_busy, a_done, a_pool_en, a_rf_wr_en, a_rf_wr_sel, a_out_valid, a_x_sel};
    checks++;
    if (got !== 7'b0000001) begin
      errors++; $display("FAIL reset_ctrl: got %b want %b", got, 7'b0000001);
    end
    checks++;
    if ({a_rf_wr_addr, a_rf_rd_addr, a_out_col, a_out_row} !== 8'h00) begin
      errors++; $display("FAIL reset_addr: got %h want 00", {a_rf_wr_addr, a_rf_rd_addr, a_out_col, a_out_row});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // in_valid without start in IDLE must not enable anything.
  task automatic test_idle_ignore();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1);
      checks++;
      if ({a_busy, a_done, a_rf_wr_en, a_pool_en, a_out_valid} !== 5'b00000) begin
        errors++; $display("FAIL idle_valid: got %b want 00000", {a_busy, a_done, a_rf_wr_en, a_pool_en, a_out_valid});
      end
    end
  endtask

  // One 4x4 frame on dut_a. gaps inserts an idle cycle between pixels; start_at re-pulses
  // start alongside that pixel; last_px < 15 stops early (used for mid-frame reset).
  task automatic run_frame(input string tag, input bit gaps, input int start_at,
                           input bit start_with_valid, input int last_px);
    logic [15:0] ov_mask;
    logic [5:0]  got, exp;
    logic [1:0]  hold;
    int r, c, n_ov;
    ov_mask = 16'hA0A0;
    n_ov = 0;
    hold = 2'd0;
    drive(1'b1, start_with_valid);
    checks++;
    if ({a_busy, a_rf_wr_en, a_pool_en, a_out_valid} !== 4'b0000) begin
      errors++; $display("FAIL %s start_cycle: got %b want 0000", tag, {a_busy, a_rf_wr_en, a_pool_en, a_out_valid});
    end
    for (int p = 0; p <= last_px; p++) begin
      if (gaps && p > 0) begin
        drive(1'b0, 1'b0);
        checks++;
        if ({a_busy, a_rf_wr_en, a_pool_en, a_out_valid, a_x_sel, a_rf_wr_sel} !== 6'b100010) begin
          errors++; $display("FAIL %s gap%0d_ctrl: got %b want 100010", tag, p,
                             {a_busy, a_rf_wr_en, a_pool_en, a_out_valid, a_x_sel, a_rf_wr_sel});
        end
        checks++;
        if (a_rf_wr_addr !== hold || a_rf_rd_addr !== hold) begin
          errors++; $display("FAIL %s gap%0d_addr: got %0d/%0d want %0d", tag, p, a_rf_wr_addr, a_rf_rd_addr, hold);
        end
      end
      drive(p == start_at, 1'b1);
      r = p / 4;
      c = p % 4;
      exp[5] = 1'b1;
      exp[4] = !((r % 2 == 1) && (c % 2 == 1));
      exp[3] = (r % 2 == 1) || (c % 2 == 1);
      exp[2] = exp[4] && exp[3];
      exp[1] = 1'b1;
      exp[0] = ov_mask[p];
      got = {a_busy, a_rf_wr_en, a_pool_en, a_rf_wr_sel, a_x_sel, a_out_valid};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL %s px%0d_ctrl: got %b want %b", tag, p, got, exp);
      end
      checks++;
      if (a_rf_wr_addr !== 2'(c / 2) || a_rf_rd_addr !== 2'(c / 2)) begin
        errors++; $display("FAIL %s px%0d_addr: got %0d/%0d want %0d", tag, p, a_rf_wr_addr, a_rf_rd_addr, c / 2);
      end
      hold = 2'(c / 2);
      if (a_out_valid === 1'b1) begin
        n_ov++;
        checks++;
        if (a_out_row !== 2'(r / 2) || a_out_col !== 2'(c / 2)) begin
          errors++; $display("FAIL %s px%0d_pos: got (%0d,%0d) want (%0d,%0d)", tag, p, a_out_row, a_out_col, r / 2, c / 2);
        end
      end
    end
    if (last_px == 15) begin
      checks++;
      if (n_ov != 4) begin
        errors++; $display("FAIL %s ov_count: got %0d want 4", tag, n_ov);
      end
      drive(1'b0, 1'b0);
      checks++;
      if ({a_done, a_busy, a_out_valid} !== 3'b100) begin
        errors++; $display("FAIL %s done_pulse: got %b want 100", tag, {a_done, a_busy, a_out_valid});
      end
      drive(1'b0, 1'b0);
      checks++;
      if ({a_done, a_busy} !== 2'b00) begin
        errors++; $display("FAIL %s after_done: got %b want 00", tag, {a_done, a_busy});
      end
    end
  endtask

  task automatic test_midframe_reset();
    run_frame("prereset", 1'b0, -1, 1'b0, 9);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_done, a_rf_wr_en, a_pool_en, a_out_valid, a_x_sel, a_rf_wr_sel} !== 7'b0000010) begin
      errors++; $display("FAIL midreset_ctrl: got %b want 0000010",
                         {a_busy, a_done, a_rf_wr_en, a_pool_en, a_out_valid, a_x_sel, a_rf_wr_sel});
    end
    checks++;
    if ({a_rf_wr_addr, a_rf_rd_addr, a_out_col, a_out_row} !== 8'h00) begin
      errors++; $display("FAIL midreset_addr: got %h want 00", {a_rf_wr_addr, a_rf_rd_addr, a_out_col, a_out_row});
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    run_frame("postreset", 1'b0, -1, 1'b0, 15);
  endtask

  // 8x2 geometry on dut_b: pooled outputs at pixels 9, 11, 13, 15, columns 0..3, row 0.
  task automatic test_narrow();
    logic [15:0] ov_mask;
    logic [3:0]  got, exp;
    int c, n_ov;
    ov_mask = 16'hAA00;
    n_ov = 0;
    drive(1'b1, 1'b0);
    for (int p = 0; p < 16; p++) begin
      drive(1'b0, 1'b1);
      c = p % 8;
      exp = {ov_mask[p], !ov_mask[p], (p >= 8) || (c % 2 == 1), 1'b1};
      got = {b_out_valid, b_rf_wr_en, b_pool_en, b_busy};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL narrow px%0d_ctrl: got %b want %b", p, got, exp);
      end
      checks++;
      if (b_rf_wr_addr !== 2'(c / 2) || b_rf_rd_addr !== 2'(c / 2)) begin
        errors++; $display("FAIL narrow px%0d_addr: got %0d/%0d want %0d", p, b_rf_wr_addr, b_rf_rd_addr, c / 2);
      end
      if (b_out_valid === 1'b1) begin
        checks++;
        if (b_out_col !== 2'(n_ov) || b_out_row !== 1'b0) begin
          errors++; $display("FAIL narrow px%0d_pos: got (%0d,%0d) want (0,%0d)", p, b_out_row, b_out_col, n_ov);
        end
        n_ov++;
      end
    end
    drive(1'b0, 1'b0);
    checks++;
    if ({b_done, b_busy} !== 2'b10 || n_ov != 4) begin
      errors++; $display("FAIL narrow_done: got done/busy %b count %0d want 10 count 4", {b_done, b_busy}, n_ov);
    end
    drive(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    run_frame("back_to_back", 1'b0, -1, 1'b0, 15);
    run_frame("gaps", 1'b1, -1, 1'b0, 15);
    run_frame("start_in_run", 1'b0, 6, 1'b0, 15);
    run_frame("start_with_valid", 1'b0, -1, 1'b1, 15);
    test_midframe_reset();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
